xmodem_loader: RTL and testbench

XMODEM_LOADER -- requirements
Module: xmodem_loader

---
 rtl/xmodem_loader.sv | 268 ++++++++++++++++++++++++++
 tb/tb_xmodem_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmodem_loader.sv
// XMODEM (checksum variant) receiver that streams 128-byte blocks from a UART
// RX FIFO into instruction memory, packing bytes little-endian into words and
// answering each block with ACK/NAK through the UART TX FIFO.
module xmodem_loader #(
  parameter int NB_UART_DATA    = 8,
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 7,
  parameter int TIMEOUT_CYCLES  = 20000000
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [NB_UART_DATA-1:0]    i_uart_rx_data,
  input  logic                       i_uart_rx_empty,
  output logic                       o_uart_rd,
  output logic                       o_uart_wr,
  output logic [NB_UART_DATA-1:0]    o_uart_wdata,
  output logic                       o_uart_tx_start,
  input  logic                       i_uart_tx_done,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overflow
);

  localparam int BLOCK_BYTES     = 128;
  localparam int BYTES_PER_WORD  = NB_INSTRUCTION / NB_UART_DATA;
  localparam int LANE_W          = $clog2(BYTES_PER_WORD);
  localparam int WORDS_PER_BLOCK = BLOCK_BYTES / BYTES_PER_WORD;
  // One extra bit so an address past the end of IMEM is visible as overflow.
  localparam int ADDR_EXT_W      = IMEM_ADDR_WIDTH + 1;
  localparam int TO_W            = $clog2(TIMEOUT_CYCLES + 1);
  // Only the bytes preceding the last byte of a word need buffering.
  localparam int WB_W            = NB_INSTRUCTION - NB_UART_DATA;

  localparam logic [NB_UART_DATA-1:0] SOH = NB_UART_DATA'(8'h01);
  localparam logic [NB_UART_DATA-1:0] EOT = NB_UART_DATA'(8'h04);
  localparam logic [NB_UART_DATA-1:0] ACK = NB_UART_DATA'(8'h06);
  localparam logic [NB_UART_DATA-1:0] NAK = NB_UART_DATA'(8'h15);

  localparam logic [7:0]            LAST_DATA    = 8'(BLOCK_BYTES - 1);
  localparam logic [TO_W-1:0]       TO_LIMIT     = TO_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_EXT_W-1:0] BLOCK_STRIDE = ADDR_EXT_W'(WORDS_PER_BLOCK);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_HDR,
    S_BLK,
    S_BLK_N,
    S_DATA,
    S_CKSUM,
    S_RESP_WR,
    S_RESP_START,
    S_RESP_WAIT
  } state_t;

  state_t state_q, state_d;

  logic                      rd_q;        // popped last cycle: enforces the pop gap
  logic [NB_UART_DATA-1:0]   blk_q;
  logic [NB_UART_DATA-1:0]   blk_n_q;
  logic [7:0]                byte_cnt_q;
  logic [NB_UART_DATA-1:0]   cksum_q;
  logic [WB_W-1:0]           word_buf_q;
  logic [NB_UART_DATA-1:0]   expected_q;
  logic [ADDR_EXT_W-1:0]     base_q;
  logic [TO_W-1:0]           to_cnt_q;
  logic [NB_UART_DATA-1:0]   resp_q;
  logic                      eot_q;

  logic                      rx_state;
  logic                      timed_state;
  logic                      pop;
  logic                      timeout;
  logic                      start_ok;
  logic [NB_UART_DATA-1:0]   blk_sum;
  logic [NB_UART_DATA-1:0]   expected_prev;
  logic                      block_ok;
  logic [ADDR_EXT_W-1:0]     word_addr;
  logic                      word_last;

  logic                      resp_we;
  logic [NB_UART_DATA-1:0]   resp_d;
  logic                      eot_set;
  logic                      advance;

  assign rx_state    = (state_q == S_WAIT_HDR) || (state_q == S_BLK) ||
                       (state_q == S_BLK_N)    || (state_q == S_DATA) ||
                       (state_q == S_CKSUM);
  assign timed_state = (state_q == S_BLK)  || (state_q == S_BLK_N) ||
                       (state_q == S_DATA) || (state_q == S_CKSUM);
  assign pop         = rx_state && !i_uart_rx_empty && !rd_q;
  assign timeout     = timed_state && !pop && (to_cnt_q == TO_LIMIT);
  assign start_ok    = (state_q == S_IDLE) && i_start;

  assign blk_sum       = blk_q + blk_n_q;
  assign expected_prev = expected_q - NB_UART_DATA'(1);
  assign block_ok      = (blk_sum == '1) && (i_uart_rx_data == cksum_q);
  assign word_addr     = base_q + ADDR_EXT_W'(byte_cnt_q >> LANE_W);
  assign word_last     = (byte_cnt_q[LANE_W-1:0] == '1);

  assign o_uart_rd = pop;
  assign o_busy    = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: non-blocking so every register in the design samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state decode plus the response-side strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d         = state_q;
    resp_we         = 1'b0;
    resp_d          = NAK;
    eot_set         = 1'b0;
    advance         = 1'b0;
    o_uart_wr       = 1'b0;
    o_uart_wdata    = '0;
    o_uart_tx_start = 1'b0;
    o_done          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_WAIT_HDR;
      end
      S_WAIT_HDR: begin
        if (pop) begin
          if (i_uart_rx_data == SOH) begin
            state_d = S_BLK;
          end else if (i_uart_rx_data == EOT) begin
            state_d = S_RESP_WR;
            resp_we = 1'b1;
            resp_d  = ACK;
            eot_set = 1'b1;
          end
        end
      end
      S_BLK: begin
        if (pop) state_d = S_BLK_N;
      end
      S_BLK_N: begin
        if (pop) state_d = S_DATA;
      end
      S_DATA: begin
        if (pop && (byte_cnt_q == LAST_DATA)) state_d = S_CKSUM;
      end
      S_CKSUM: begin
        if (pop) begin
          state_d = S_RESP_WR;
          resp_we = 1'b1;
          if (block_ok && (blk_q == expected_q)) begin
            resp_d  = ACK;
            advance = 1'b1;
          end else if (block_ok && (blk_q == expected_prev)) begin
            // Sender missed our ACK and repeated the block: acknowledge only.
            resp_d = ACK;
          end
        end
      end
      S_RESP_WR: begin
        o_uart_wr    = 1'b1;
        o_uart_wdata = resp_q;
        state_d      = S_RESP_START;
      end
      S_RESP_START: begin
        o_uart_tx_start = 1'b1;
        state_d         = S_RESP_WAIT;
      end
      S_RESP_WAIT: begin
        if (i_uart_tx_done) begin
          if (eot_q) begin
            o_done  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_HDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled sender inside a block is NAKed; base is left alone.
    if (timeout) begin
      state_d = S_RESP_WR;
      resp_we = 1'b1;
      resp_d  = NAK;
    end
  end

  // Receive datapath: header capture, checksum, word packing and IMEM writes.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q         <= 1'b0;
      blk_q        <= '0;
      blk_n_q      <= '0;
      byte_cnt_q   <= '0;
      cksum_q      <= '0;
      word_buf_q   <= '0;
      expected_q   <= '0;
      base_q       <= '0;
      to_cnt_q     <= '0;
      resp_q       <= '0;
      eot_q        <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_overflow   <= 1'b0;
    end else begin
      rd_q      <= pop;
      o_imem_we <= 1'b0;

      if (start_ok) begin
        expected_q <= NB_UART_DATA'(1);
        base_q     <= '0;
        o_overflow <= 1'b0;
        eot_q      <= 1'b0;
      end

      if (resp_we) resp_q <= resp_d;
      if (eot_set) eot_q  <= 1'b1;

      // Idle counter runs only inside a block and restarts on each pop.
      if (timed_state && !pop && !timeout) to_cnt_q <= to_cnt_q + TO_W'(1);
      else                                 to_cnt_q <= '0;

      if (pop) begin
        unique case (state_q)
          S_BLK:   blk_q <= i_uart_rx_data;
          S_BLK_N: begin
            blk_n_q    <= i_uart_rx_data;
            byte_cnt_q <= '0;
            cksum_q    <= '0;
          end
          S_DATA: begin
            byte_cnt_q <= byte_cnt_q + 8'd1;
            cksum_q    <= cksum_q + i_uart_rx_data;
            word_buf_q <= {i_uart_rx_data, word_buf_q[WB_W-1:NB_UART_DATA]};
            if (word_last) begin
              if (!word_addr[IMEM_ADDR_WIDTH]) begin
                o_imem_we    <= 1'b1;
                o_imem_addr  <= word_addr[IMEM_ADDR_WIDTH-1:0];
                o_imem_wdata <= {i_uart_rx_data, word_buf_q};
              end else begin
                o_overflow <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end

      if (advance) begin
        expected_q <= expected_q + NB_UART_DATA'(1);
        // Once past the end of IMEM the base parks there; every write is dropped anyway.
        if (!base_q[IMEM_ADDR_WIDTH]) base_q <= base_q + BLOCK_STRIDE;
      end
    end
  end

endmodule

// File: tb/tb_xmodem_loader.sv
// Directed bench for xmodem_loader: a small UART FIFO model feeds blocks,
// responses and IMEM writes are logged at the falling edge and compared
// against values the bench builds itself.
module tb_xmodem_loader;

  localparam int AW = 7;
  localparam int TO = 1000;

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EOT = 8'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [7:0]    i_uart_rx_data = '0;
  logic          i_uart_rx_empty = 1'b1;
  logic          i_uart_tx_done = 1'b0;
  logic          o_uart_rd;
  logic          o_uart_wr;
  logic [7:0]    o_uart_wdata;
  logic          o_uart_tx_start;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic          o_busy;
  logic          o_done;
  logic          o_overflow;

  xmodem_loader #(
    .NB_UART_DATA(8),
    .NB_INSTRUCTION(32),
    .IMEM_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_uart_rx_data(i_uart_rx_data),
    .i_uart_rx_empty(i_uart_rx_empty),
    .o_uart_rd(o_uart_rd),
    .o_uart_wr(o_uart_wr),
    .o_uart_wdata(o_uart_wdata),
    .o_uart_tx_start(o_uart_tx_start),
    .i_uart_tx_done(i_uart_tx_done),
    .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  int          we_log[$];
  logic [31:0] imem [128];
  int          done_cnt = 0;
  int          underflow = 0;
  int          tx_cnt = 0;
  logic [7:0]  blk_data [128];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // UART side: pops take effect just after the edge that consumed the byte,
  // and tx_done follows tx_start by three cycles.
  initial begin : uart_model
    logic       do_pop;
    logic       start_seen;
    logic [7:0] tmp;
    forever begin
      @(negedge clk);
      do_pop     = o_uart_rd;
      start_seen = o_uart_tx_start;
      @(posedge clk);
      #1;
      if (do_pop && rx_q.size() > 0) tmp = rx_q.pop_front();
      i_uart_tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) i_uart_tx_done = 1'b1;
      end
      if (start_seen) tx_cnt = 3;
      i_uart_rx_empty = (rx_q.size() == 0);
      i_uart_rx_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    end
  end

  // Output monitor: responses, IMEM writes, done pulses, illegal pops.
  always @(negedge clk) begin
    if (o_uart_wr) tx_log.push_back(o_uart_wdata);
    if (o_imem_we) begin
      imem[o_imem_addr] = o_imem_wdata;
      we_log.push_back(int'(o_imem_addr));
    end
    if (o_done) done_cnt++;
    if (o_uart_rd && i_uart_rx_empty) underflow++;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] data_sum();
    logic [7:0] s = '0;
    for (int i = 0; i < 128; i++) s = s + blk_data[i];
    return s;
  endfunction

  function automatic logic [31:0] data_word(input int j);
    return {blk_data[4*j+3], blk_data[4*j+2], blk_data[4*j+1], blk_data[4*j]};
  endfunction

  function automatic int imem_mismatches(input int base);
    int n = 0;
    for (int j = 0; j < 32; j++) if (imem[base+j] !== data_word(j)) n++;
    return n;
  endfunction

  function automatic logic addrs_sequential(input int base);
    logic ok = (we_log.size() == 32);
    for (int i = 0; i < we_log.size(); i++) if (we_log[i] != base + i) ok = 1'b0;
    return ok;
  endfunction

  task automatic fill_pattern(input logic [7:0] seed);
    for (int i = 0; i < 128; i++) blk_data[i] = seed + 8'(i * 3);
  endtask

  // Word 0 = 0x00108093, words 1..19 = {i,00,02,93}, the rest padded with 0x1A.
  task automatic fill_program();
    for (int i = 0; i < 128; i++) blk_data[i] = 8'h1A;
    blk_data[0] = 8'h93; blk_data[1] = 8'h80; blk_data[2] = 8'h10; blk_data[3] = 8'h00;
    for (int w = 1; w < 20; w++) begin
      blk_data[4*w]   = 8'h93;
      blk_data[4*w+1] = 8'h02;
      blk_data[4*w+2] = 8'h00;
      blk_data[4*w+3] = 8'(w);
    end
  endtask

  task automatic send_block(input logic [7:0] blk, input logic [7:0] blk_n, input logic [7:0] ck_err);
    rx_q.push_back(SOH);
    rx_q.push_back(blk);
    rx_q.push_back(blk_n);
    for (int i = 0; i < 128; i++) rx_q.push_back(blk_data[i]);
    rx_q.push_back(data_sum() + ck_err);
  endtask

  task automatic expect_tx(input string tag, input int n, input logic [7:0] val);
    int k = 0;
    while (tx_log.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_cnt"}, 64'(tx_log.size()), 64'(n));
    if (tx_log.size() >= n) check(tag, 64'(tx_log[n-1]), 64'(val));
  endtask

  task automatic wait_done(input string tag, input int target);
    int k = 0;
    while (done_cnt < target && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check(tag, 64'(done_cnt), 64'(target));
    check({tag, "_idle"}, 64'(o_busy), 64'(0));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic new_transfer();
    tx_log.delete();
    we_log.delete();
    pulse_start();
  endtask

  initial begin : stimulus
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_strobes", 64'({o_uart_rd, o_uart_wr, o_uart_tx_start, o_imem_we, o_done, o_overflow}), 64'(0));
    check("rst_data", 64'({o_uart_wdata, o_imem_addr, o_imem_wdata}), 64'(0));

    // Start asserted together with reset release is taken on the first edge.
    i_rst_n = 1'b1;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
    check("start_first_edge", 64'(o_busy), 64'(1));

    // Single program block then EOT.
    fill_program();
    send_block(8'h01, 8'hFE, 8'h00);
    expect_tx("prog_ack", 1, ACK);
    check("prog_order", 64'(addrs_sequential(0)), 64'(1));
    check("prog_w0", 64'(imem[0]), 64'(32'h00108093));
    check("prog_w19", 64'(imem[19]), 64'(32'h13000293));
    check("prog_w20", 64'(imem[20]), 64'(32'h1A1A1A1A));
    check("prog_w31", 64'(imem[31]), 64'(32'h1A1A1A1A));
    rx_q.push_back(EOT);
    expect_tx("prog_eot_ack", 2, ACK);
    wait_done("prog_done", 1);

    // Bad checksum, resend, then the next block lands at word 32.
    new_transfer();
    fill_pattern(8'h40);
    send_block(8'h01, 8'hFE, 8'h01);
    expect_tx("badck_nak", 1, NAK);
    fill_pattern(8'h55);
    send_block(8'h01, 8'hFE, 8'h00);
    expect_tx("resend_ack", 2, ACK);
    check("resend_imem", 64'(imem_mismatches(0)), 64'(0));
    we_log.delete();
    fill_pattern(8'h70);
    send_block(8'h02, 8'hFD, 8'h00);
    expect_tx("blk2_ack", 3, ACK);
    check("blk2_order", 64'(addrs_sequential(32)), 64'(1));
    check("blk2_imem", 64'(imem_mismatches(32)), 64'(0));
    rx_q.push_back(EOT);
    expect_tx("t2_eot_ack", 4, ACK);
    wait_done("t2_done", 2);

    // Bad complement, wrong block, then good block, retransmit, next block.
    new_transfer();
    fill_pattern(8'h11);
    send_block(8'h01, 8'hFD, 8'h00);
    expect_tx("badcmp_nak", 1, NAK);
    send_block(8'h02, 8'hFD, 8'h00);
    expect_tx("wrongblk_nak", 2, NAK);
    we_log.delete();
    send_block(8'h01, 8'hFE, 8'h00);
    expect_tx("blk1_ack", 3, ACK);
    check("blk1_base", 64'(addrs_sequential(0)), 64'(1));
    we_log.delete();
    send_block(8'h01, 8'hFE, 8'h00);
    expect_tx("retx_ack", 4, ACK);
    check("retx_base", 64'(addrs_sequential(32)), 64'(1));
    we_log.delete();
    fill_pattern(8'h22);
    send_block(8'h02, 8'hFD, 8'h00);
    expect_tx("after_retx_ack", 5, ACK);
    check("after_retx_base", 64'(addrs_sequential(32)), 64'(1));
    check("after_retx_imem", 64'(imem_mismatches(32)), 64'(0));
    rx_q.push_back(EOT);
    expect_tx("t3_eot_ack", 6, ACK);
    wait_done("t3_done", 3);

    // Five good blocks: the fifth overflows a 128-word IMEM but is still ACKed.
    new_transfer();
    for (int k = 1; k <= 4; k++) begin
      fill_pattern(8'(k * 16));
      send_block(8'(k), ~8'(k), 8'h00);
      expect_tx("fill_ack", k, ACK);
    end
    check("fill_writes", 64'(we_log.size()), 64'(128));
    check("fill_no_ovf", 64'(o_overflow), 64'(0));
    check("fill_blk4_imem", 64'(imem_mismatches(96)), 64'(0));
    we_log.delete();
    fill_pattern(8'h99);
    send_block(8'h05, 8'hFA, 8'h00);
    expect_tx("ovf_ack", 5, ACK);
    check("ovf_no_writes", 64'(we_log.size()), 64'(0));
    check("ovf_flag", 64'(o_overflow), 64'(1));
    rx_q.push_back(EOT);
    expect_tx("t4_eot_ack", 6, ACK);
    wait_done("t4_done", 4);
    check("ovf_sticky", 64'(o_overflow), 64'(1));
    new_transfer();
    check("ovf_cleared", 64'(o_overflow), 64'(0));

    // Sender stalls after 10 data bytes.
    rx_q.push_back(SOH);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'hFE);
    for (int i = 0; i < 10; i++) rx_q.push_back(8'(i));
    n = 0;
    while (rx_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (tx_log.size() < 1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", 64'(n >= 990 && n <= 1010), 64'(1));
    expect_tx("to_nak", 1, NAK);
    repeat (4) @(negedge clk);
    check("to_busy", 64'(o_busy), 64'(1));
    repeat (1500) @(negedge clk);
    check("hdr_no_timeout", 64'(tx_log.size()), 64'(1));
    we_log.delete();
    fill_pattern(8'h33);
    send_block(8'h01, 8'hFE, 8'h00);
    expect_tx("to_then_ack", 2, ACK);
    check("to_base_kept", 64'(addrs_sequential(0)), 64'(1));
    rx_q.push_back(EOT);
    expect_tx("t5_eot_ack", 3, ACK);
    wait_done("t5_done", 5);

    // Reset in the middle of a block, then a clean restart.
    new_transfer();
    fill_pattern(8'h44);
    rx_q.push_back(SOH);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'hFE);
    for (int i = 0; i < 40; i++) rx_q.push_back(blk_data[i]);
    n = 0;
    while (rx_q.size() > 20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_busy", 64'(o_busy), 64'(1));
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(o_busy), 64'(0));
    check("mid_rst_strobes", 64'({o_uart_rd, o_uart_wr, o_uart_tx_start, o_imem_we, o_done, o_overflow}), 64'(0));
    check("mid_rst_data", 64'({o_uart_wdata, o_imem_addr, o_imem_wdata}), 64'(0));
    rx_q.delete();
    tx_log.delete();
    we_log.delete();
    tx_cnt = 0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    new_transfer();
    fill_pattern(8'h66);
    send_block(8'h01, 8'hFE, 8'h00);
    expect_tx("restart_ack", 1, ACK);
    check("restart_base", 64'(addrs_sequential(0)), 64'(1));
    check("restart_imem", 64'(imem_mismatches(0)), 64'(0));
    rx_q.push_back(EOT);
    expect_tx("t6_eot_ack", 2, ACK);
    wait_done("t6_done", 6);

    check("no_underflow", 64'(underflow), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
